// File: rtl/bank_isu_pkg.sv
// rtl/bank_isu_pkg.sv - shared widths and entry payload type for the bank issue scheduler
package bank_isu_pkg;

   localparam int PTR_WIDTH   = 3;
   localparam int NUM_CH      = 4;
   localparam int CH_W        = $clog2(NUM_CH);
   localparam int CREDIT_W    = 3;
   localparam int CREDIT_INIT = 4;
   localparam int ROB_W       = 3;
   localparam int SWO_W       = 7;
   localparam int WBUF_W      = 8;

   // Everything carried from enqueue to issue; line_state is {offset1, offset0}
   typedef struct packed {
      logic [ROB_W-1:0]  rob_id;
      logic [CH_W-1:0]   ch_id;
      logic [1:0]        opcode;
      logic [SWO_W-1:0]  swo;
      logic [WBUF_W-1:0] wbuf_id;
      logic [3:0]        line_state;
   } entry_t;

endpackage

// File: rtl/bank_isu_credit_ctr.sv
// rtl/bank_isu_credit_ctr.sv - per-channel downstream credit counter, saturating at max
module bank_isu_credit_ctr #(
   parameter int CREDIT_W    = 3,
   parameter int CREDIT_INIT = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                consume_i,
   input  logic                return_i,
   output logic                nonzero_o,
   output logic [CREDIT_W-1:0] count_o
);

   localparam logic [CREDIT_W-1:0] CNT_MAX  = '1;
   localparam logic [CREDIT_W-1:0] CNT_INIT = CREDIT_W'(CREDIT_INIT);

   logic [CREDIT_W-1:0] count_q, count_d;

   // A consume and a return in the same cycle cancel; a return at max is dropped
   always_comb begin
      count_d = count_q;
      if (consume_i && !return_i) begin
         count_d = count_q - CREDIT_W'(1);
      end else if (!consume_i && return_i && (count_q != CNT_MAX)) begin
         count_d = count_q + CREDIT_W'(1);
      end
   end

   // Credit register, restored to the full allowance on reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= CNT_INIT;
      end else begin
         count_q <= count_d;
      end
   end

   assign nonzero_o = (count_q != '0);
   assign count_o   = count_q;

   // Downstream returned more credits than it was ever given
   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(return_i && !consume_i && (count_q == CNT_MAX)));

   // Issue logic must never spend a credit that is not there
   a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(consume_i && (count_q == '0)));

endmodule

// File: rtl/bank_isu_iq_sched.sv
// rtl/bank_isu_iq_sched.sv - in-order bank issue queue with linefill wakeup and channel credits
module bank_isu_iq_sched #(
   parameter int PTR_WIDTH   = 3,
   parameter int NUM_CH      = 4,
   parameter int CREDIT_W    = 3,
   parameter int CREDIT_INIT = 4,
   parameter int ROB_W       = 3,
   parameter int SWO_W       = 7,
   parameter int WBUF_W      = 8,
   localparam int CH_W       = $clog2(NUM_CH)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_allowIn_o,
   input  logic                 req_need_linefill_i,
   input  logic [ROB_W-1:0]     req_rob_id_i,
   input  logic [CH_W-1:0]      req_ch_id_i,
   input  logic [1:0]           req_opcode_i,
   input  logic [SWO_W-1:0]     req_set_way_offset_i,
   input  logic [WBUF_W-1:0]    req_wbuffer_id_i,
   input  logic [1:0]           req_cacheline_offset0_state_i,
   input  logic [1:0]           req_cacheline_offset1_state_i,
   input  logic                 lf_done_valid_i,
   input  logic [SWO_W-2:0]     lf_done_set_way_i,
   input  logic [NUM_CH-1:0]    credit_ret_i,
   output logic                 iss_valid_o,
   input  logic                 iss_ready_i,
   output logic [ROB_W-1:0]     iss_rob_id_o,
   output logic [CH_W-1:0]      iss_ch_id_o,
   output logic [1:0]           iss_opcode_o,
   output logic [SWO_W-1:0]     iss_set_way_offset_o,
   output logic [WBUF_W-1:0]    iss_wbuffer_id_o,
   output logic [3:0]           iss_cacheline_state_o,
   output logic [PTR_WIDTH:0]   queue_count_o
);

   import bank_isu_pkg::*;

   localparam int DEPTH = 2 ** PTR_WIDTH;

   logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH:0]   count_q, count_d;
   logic [DEPTH-1:0]     valid_q, valid_d;
   logic [DEPTH-1:0]     mshr_q, mshr_d;
   entry_t               mem_q [DEPTH];
   entry_t               req_entry;
   entry_t               head;
   logic                 enq;
   logic                 fire;
   logic                 req_lf_hit;
   logic [NUM_CH-1:0]    credit_nz;
   logic [NUM_CH-1:0]    consume;
   logic [CREDIT_W-1:0]  credit_cnt [NUM_CH];

   // Head selection and issue qualification, all from registered state
   always_comb begin
      head          = mem_q[rd_ptr_q];
      req_allowIn_o = (count_q != (PTR_WIDTH+1)'(DEPTH));
      enq           = req_valid_i & req_allowIn_o;
      iss_valid_o   = valid_q[rd_ptr_q] & mshr_q[rd_ptr_q] & credit_nz[head.ch_id];
      fire          = iss_valid_o & iss_ready_i;
   end

   // Pack the incoming request and check it against a linefill completing this cycle
   always_comb begin
      req_entry.rob_id     = req_rob_id_i;
      req_entry.ch_id      = req_ch_id_i;
      req_entry.opcode     = req_opcode_i;
      req_entry.swo        = req_set_way_offset_i;
      req_entry.wbuf_id    = req_wbuffer_id_i;
      req_entry.line_state = {req_cacheline_offset1_state_i, req_cacheline_offset0_state_i};
      req_lf_hit           = lf_done_valid_i & (req_set_way_offset_i[SWO_W-1:1] == lf_done_set_way_i);
   end

   // Next-state for occupancy, pointers, valid bits and linefill-ready bits
   always_comb begin
      valid_d  = valid_q;
      mshr_d   = mshr_q;
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(fire);
      wr_ptr_d = wr_ptr_q + PTR_WIDTH'(enq);
      count_d  = count_q + (PTR_WIDTH+1)'(enq) - (PTR_WIDTH+1)'(fire);
      for (int i = 0; i < DEPTH; i++) begin
         if (lf_done_valid_i && valid_q[i] && (mem_q[i].swo[SWO_W-1:1] == lf_done_set_way_i)) begin
            mshr_d[i] = 1'b1;
         end
      end
      if (fire) begin
         valid_d[rd_ptr_q] = 1'b0;
      end
      // The enqueue slot is always empty, so it cannot collide with the fire slot
      if (enq) begin
         valid_d[wr_ptr_q] = 1'b1;
         mshr_d[wr_ptr_q]  = ~req_need_linefill_i | req_lf_hit;
      end
   end

   // Control state; reset drops every entry
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
         mshr_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         mshr_q   <= mshr_d;
      end
   end

   // Payload storage; only meaningful where valid is set, so it is not reset
   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem_q[wr_ptr_q] <= req_entry;
      end
   end

   // One credit counter per downstream channel; only the head's channel is spent
   for (genvar c = 0; c < NUM_CH; c++) begin : g_credit
      assign consume[c] = fire & (head.ch_id == CH_W'(c));
      bank_isu_credit_ctr #(
         .CREDIT_W    (CREDIT_W),
         .CREDIT_INIT (CREDIT_INIT)
      ) u_credit_ctr (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .consume_i (consume[c]),
         .return_i  (credit_ret_i[c]),
         .nonzero_o (credit_nz[c]),
         .count_o   (credit_cnt[c])
      );
   end

   assign iss_rob_id_o          = head.rob_id;
   assign iss_ch_id_o           = head.ch_id;
   assign iss_opcode_o          = head.opcode;
   assign iss_set_way_offset_o  = head.swo;
   assign iss_wbuffer_id_o      = head.wbuf_id;
   assign iss_cacheline_state_o = head.line_state;
   assign queue_count_o         = count_q;

   // An issuable head always has a credit behind it
   a_head_has_credit: assert property (@(posedge clk_i) disable iff (rst_i)
      iss_valid_o |-> (credit_cnt[head.ch_id] != '0));

endmodule

// File: tb/tb_bank_isu_iq_sched.sv
// tb/tb_bank_isu_iq_sched.sv - directed self-checking bench for bank_isu_iq_sched
module tb_bank_isu_iq_sched;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       req_valid_i;
   logic       req_allowIn_o;
   logic       req_need_linefill_i;
   logic [2:0] req_rob_id_i;
   logic [1:0] req_ch_id_i;
   logic [1:0] req_opcode_i;
   logic [6:0] req_set_way_offset_i;
   logic [7:0] req_wbuffer_id_i;
   logic [1:0] req_cacheline_offset0_state_i;
   logic [1:0] req_cacheline_offset1_state_i;
   logic       lf_done_valid_i;
   logic [5:0] lf_done_set_way_i;
   logic [3:0] credit_ret_i;
   logic       iss_valid_o;
   logic       iss_ready_i;
   logic [2:0] iss_rob_id_o;
   logic [1:0] iss_ch_id_o;
   logic [1:0] iss_opcode_o;
   logic [6:0] iss_set_way_offset_o;
   logic [7:0] iss_wbuffer_id_o;
   logic [3:0] iss_cacheline_state_o;
   logic [3:0] queue_count_o;

   int vecs = 0;
   int errs = 0;

   bank_isu_iq_sched dut (
      .clk_i                         (clk),
      .rst_i                         (rst_i),
      .req_valid_i                   (req_valid_i),
      .req_allowIn_o                 (req_allowIn_o),
      .req_need_linefill_i           (req_need_linefill_i),
      .req_rob_id_i                  (req_rob_id_i),
      .req_ch_id_i                   (req_ch_id_i),
      .req_opcode_i                  (req_opcode_i),
      .req_set_way_offset_i          (req_set_way_offset_i),
      .req_wbuffer_id_i              (req_wbuffer_id_i),
      .req_cacheline_offset0_state_i (req_cacheline_offset0_state_i),
      .req_cacheline_offset1_state_i (req_cacheline_offset1_state_i),
      .lf_done_valid_i               (lf_done_valid_i),
      .lf_done_set_way_i             (lf_done_set_way_i),
      .credit_ret_i                  (credit_ret_i),
      .iss_valid_o                   (iss_valid_o),
      .iss_ready_i                   (iss_ready_i),
      .iss_rob_id_o                  (iss_rob_id_o),
      .iss_ch_id_o                   (iss_ch_id_o),
      .iss_opcode_o                  (iss_opcode_o),
      .iss_set_way_offset_o          (iss_set_way_offset_o),
      .iss_wbuffer_id_o              (iss_wbuffer_id_o),
      .iss_cacheline_state_o         (iss_cacheline_state_o),
      .queue_count_o                 (queue_count_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      req_valid_i = 1'b0;
      req_need_linefill_i = 1'b0;
      req_rob_id_i = '0;
      req_ch_id_i = '0;
      req_opcode_i = '0;
      req_set_way_offset_i = '0;
      req_wbuffer_id_i = '0;
      req_cacheline_offset0_state_i = '0;
      req_cacheline_offset1_state_i = '0;
      lf_done_valid_i = 1'b0;
      lf_done_set_way_i = '0;
      credit_ret_i = '0;
      iss_ready_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   // Present one request for a single clock edge
   task automatic put_req(input logic [2:0] rob, input logic [1:0] ch, input logic [6:0] swo,
                          input logic need, input logic [7:0] wbuf);
      req_valid_i = 1'b1;
      req_rob_id_i = rob;
      req_ch_id_i = ch;
      req_opcode_i = ch;
      req_set_way_offset_i = swo;
      req_need_linefill_i = need;
      req_wbuffer_id_i = wbuf;
      req_cacheline_offset0_state_i = rob[1:0];
      req_cacheline_offset1_state_i = ~rob[1:0];
      tick();
      req_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vecs++; if (iss_valid_o !== 1'b0) begin errs++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid_o); end
      vecs++; if (req_allowIn_o !== 1'b1) begin errs++; $display("FAIL reset_allowin: got %b want 1", req_allowIn_o); end
      vecs++; if (queue_count_o !== 4'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", queue_count_o); end
   endtask

   task automatic test_single();
      do_reset();
      iss_ready_i = 1'b1;
      put_req(3'd5, 2'd2, 7'h33, 1'b0, 8'h11);
      vecs++; if (iss_valid_o !== 1'b1) begin errs++; $display("FAIL single_valid: got %b want 1", iss_valid_o); end
      vecs++; if (iss_rob_id_o !== 3'd5) begin errs++; $display("FAIL single_rob: got %0d want 5", iss_rob_id_o); end
      vecs++; if (iss_ch_id_o !== 2'd2) begin errs++; $display("FAIL single_ch: got %0d want 2", iss_ch_id_o); end
      vecs++; if (iss_cacheline_state_o !== 4'b1001) begin errs++; $display("FAIL single_state: got %b want 1001", iss_cacheline_state_o); end
      vecs++; if (queue_count_o !== 4'd1) begin errs++; $display("FAIL single_count1: got %0d want 1", queue_count_o); end
      tick();
      vecs++; if (queue_count_o !== 4'd0) begin errs++; $display("FAIL single_count0: got %0d want 0", queue_count_o); end
      vecs++; if (iss_valid_o !== 1'b0) begin errs++; $display("FAIL single_empty: got %b want 0", iss_valid_o); end
   endtask

   task automatic test_fill_and_wrap();
      logic [2:0] r;
      logic [1:0] c;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         r = 3'(i);
         c = 2'(i);
         put_req(r, c, 7'(i), 1'b0, 8'hA0 + 8'(i));
      end
      vecs++; if (queue_count_o !== 4'd8) begin errs++; $display("FAIL fill_count: got %0d want 8", queue_count_o); end
      vecs++; if (req_allowIn_o !== 1'b0) begin errs++; $display("FAIL fill_allowin: got %b want 0", req_allowIn_o); end
      put_req(3'd7, 2'd3, 7'h7F, 1'b0, 8'hFF);
      vecs++; if (queue_count_o !== 4'd8) begin errs++; $display("FAIL fill_drop: got %0d want 8", queue_count_o); end
      iss_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         vecs++; if (iss_valid_o !== 1'b1 || iss_rob_id_o !== 3'(i) || iss_wbuffer_id_o !== 8'hA0 + 8'(i) || iss_opcode_o !== 2'(i))
            begin errs++; $display("FAIL fill_order%0d: got v=%b rob=%0d wbuf=%h op=%0d want v=1 rob=%0d wbuf=%h op=%0d",
                                   i, iss_valid_o, iss_rob_id_o, iss_wbuffer_id_o, iss_opcode_o, i, 8'hA0 + 8'(i), i % 4); end
         tick();
      end
      vecs++; if (queue_count_o !== 4'd0) begin errs++; $display("FAIL fill_drained: got %0d want 0", queue_count_o); end
      put_req(3'd3, 2'd0, 7'h01, 1'b0, 8'h55);
      vecs++; if (iss_valid_o !== 1'b1 || iss_wbuffer_id_o !== 8'h55) begin errs++; $display("FAIL wrap_issue: got v=%b wbuf=%h want v=1 wbuf=55", iss_valid_o, iss_wbuffer_id_o); end
      tick();
      vecs++; if (queue_count_o !== 4'd0) begin errs++; $display("FAIL wrap_count: got %0d want 0", queue_count_o); end
   endtask

   task automatic test_linefill_wait();
      do_reset();
      iss_ready_i = 1'b1;
      put_req(3'd1, 2'd0, 7'h2A, 1'b1, 8'h01);
      put_req(3'd2, 2'd1, 7'h10, 1'b0, 8'h02);
      vecs++; if (iss_valid_o !== 1'b0) begin errs++; $display("FAIL lf_blocked: got %b want 0", iss_valid_o); end
      vecs++; if (queue_count_o !== 4'd2) begin errs++; $display("FAIL lf_count: got %0d want 2", queue_count_o); end
      lf_done_valid_i = 1'b1;
      lf_done_set_way_i = 6'h14;
      tick();
      lf_done_valid_i = 1'b0;
      vecs++; if (iss_valid_o !== 1'b0) begin errs++; $display("FAIL lf_nomatch: got %b want 0", iss_valid_o); end
      lf_done_valid_i = 1'b1;
      lf_done_set_way_i = 6'h15;
      tick();
      lf_done_valid_i = 1'b0;
      vecs++; if (iss_valid_o !== 1'b1 || iss_rob_id_o !== 3'd1) begin errs++; $display("FAIL lf_wake: got v=%b rob=%0d want v=1 rob=1", iss_valid_o, iss_rob_id_o); end
      tick();
      vecs++; if (iss_valid_o !== 1'b1 || iss_rob_id_o !== 3'd2) begin errs++; $display("FAIL lf_younger: got v=%b rob=%0d want v=1 rob=2", iss_valid_o, iss_rob_id_o); end
      tick();
      vecs++; if (queue_count_o !== 4'd0) begin errs++; $display("FAIL lf_drained: got %0d want 0", queue_count_o); end
   endtask

   task automatic test_lf_bypass();
      do_reset();
      lf_done_valid_i = 1'b1;
      lf_done_set_way_i = 6'h15;
      put_req(3'd6, 2'd3, 7'h2B, 1'b1, 8'h66);
      lf_done_valid_i = 1'b0;
      vecs++; if (iss_valid_o !== 1'b1 || iss_rob_id_o !== 3'd6) begin errs++; $display("FAIL bypass_wake: got v=%b rob=%0d want v=1 rob=6", iss_valid_o, iss_rob_id_o); end
      iss_ready_i = 1'b1;
      tick();
      vecs++; if (queue_count_o !== 4'd0) begin errs++; $display("FAIL bypass_drain: got %0d want 0", queue_count_o); end
   endtask

   task automatic test_credit();
      do_reset();
      for (int i = 0; i < 5; i++) put_req(3'(i), 2'd1, 7'(i), 1'b0, 8'(i));
      iss_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vecs++; if (iss_valid_o !== 1'b1 || iss_rob_id_o !== 3'(i)) begin errs++; $display("FAIL credit_issue%0d: got v=%b rob=%0d want v=1 rob=%0d", i, iss_valid_o, iss_rob_id_o, i); end
         tick();
      end
      vecs++; if (iss_valid_o !== 1'b0 || queue_count_o !== 4'd1) begin errs++; $display("FAIL credit_stall: got v=%b cnt=%0d want v=0 cnt=1", iss_valid_o, queue_count_o); end
      tick();
      vecs++; if (iss_valid_o !== 1'b0) begin errs++; $display("FAIL credit_stall2: got %b want 0", iss_valid_o); end
      credit_ret_i = 4'b0010;
      tick();
      credit_ret_i = 4'b0000;
      vecs++; if (iss_valid_o !== 1'b1 || iss_rob_id_o !== 3'd4) begin errs++; $display("FAIL credit_return: got v=%b rob=%0d want v=1 rob=4", iss_valid_o, iss_rob_id_o); end
      credit_ret_i = 4'b0010;
      tick();
      credit_ret_i = 4'b0000;
      vecs++; if (queue_count_o !== 4'd0) begin errs++; $display("FAIL credit_fire_ret: got cnt=%0d want 0", queue_count_o); end
      iss_ready_i = 1'b0;
      put_req(3'd5, 2'd1, 7'h05, 1'b0, 8'h05);
      put_req(3'd6, 2'd1, 7'h06, 1'b0, 8'h06);
      iss_ready_i = 1'b1;
      vecs++; if (iss_valid_o !== 1'b1 || iss_rob_id_o !== 3'd5) begin errs++; $display("FAIL credit_kept: got v=%b rob=%0d want v=1 rob=5", iss_valid_o, iss_rob_id_o); end
      tick();
      vecs++; if (iss_valid_o !== 1'b0 || queue_count_o !== 4'd1) begin errs++; $display("FAIL credit_one_left: got v=%b cnt=%0d want v=0 cnt=1", iss_valid_o, queue_count_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) put_req(3'(i), 2'd0, 7'(i), 1'b0, 8'(i));
      iss_ready_i = 1'b1;
      tick();
      tick();
      iss_ready_i = 1'b0;
      vecs++; if (queue_count_o !== 4'd3) begin errs++; $display("FAIL mid_pre_count: got %0d want 3", queue_count_o); end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      vecs++; if (queue_count_o !== 4'd0 || iss_valid_o !== 1'b0 || req_allowIn_o !== 1'b1)
         begin errs++; $display("FAIL mid_reset: got cnt=%0d v=%b allow=%b want cnt=0 v=0 allow=1", queue_count_o, iss_valid_o, req_allowIn_o); end
      for (int i = 0; i < 5; i++) put_req(3'(i + 2), 2'd0, 7'(i), 1'b0, 8'(i));
      iss_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vecs++; if (iss_valid_o !== 1'b1 || iss_rob_id_o !== 3'(i + 2)) begin errs++; $display("FAIL mid_credit%0d: got v=%b rob=%0d want v=1 rob=%0d", i, iss_valid_o, iss_rob_id_o, (i + 2) % 8); end
         tick();
      end
      vecs++; if (iss_valid_o !== 1'b0 || queue_count_o !== 4'd1) begin errs++; $display("FAIL mid_exhaust: got v=%b cnt=%0d want v=0 cnt=1", iss_valid_o, queue_count_o); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_and_wrap();
      test_linefill_wait();
      test_lf_bypass();
      test_credit();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/bank_isu_iq_sched.md
Name: bank_isu_iq_sched

Overview:
Parametrised successor of the bank issue queue. Requests are buffered in order, as before. Unlike the first generation, this block also issues them. An entry is released from the head only when both conditions hold:
- its linefill dependency is resolved, either at enqueue or by a linefill-done broadcast;
- its channel holds a downstream credit.
It sits between the bank tag-lookup stage and the per-channel data pipelines.

Parameters:
PTR_WIDTH, 3, log2 of queue depth; DEPTH = 2**PTR_WIDTH
NUM_CH, 4, number of downstream channels; CH_W = clog2(NUM_CH)
CREDIT_W, 3, width of each channel credit counter
CREDIT_INIT, 4, credits per channel after reset; must be <= 2**CREDIT_W-1
ROB_W, 3, ROB id width
SWO_W, 7, set/way/offset width; bit 0 is the line offset, bits [SWO_W-1:1] are set/way
WBUF_W, 8, write-buffer id width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
req_valid_i  in  1  enqueue request
req_allowIn_o  out  1  queue not full
req_need_linefill_i  in  1  entry must wait for linefill-done
req_rob_id_i  in  ROB_W  ROB id
req_ch_id_i  in  CH_W  target channel
req_opcode_i  in  2  opcode
req_set_way_offset_i  in  SWO_W  set/way/offset
req_wbuffer_id_i  in  WBUF_W  write-buffer id
req_cacheline_offset0_state_i  in  2  line state, offset 0
req_cacheline_offset1_state_i  in  2  line state, offset 1
lf_done_valid_i  in  1  linefill completed
lf_done_set_way_i  in  SWO_W-1  set/way of completed linefill
credit_ret_i  in  NUM_CH  one credit returned per set bit
iss_valid_o  out  1  head entry issuable
iss_ready_i  in  1  downstream accepts
iss_rob_id_o, iss_ch_id_o, iss_opcode_o, iss_set_way_offset_o, iss_wbuffer_id_o  out  as req  head payload
iss_cacheline_state_o  out  4  {offset1_state, offset0_state}
queue_count_o  out  PTR_WIDTH+1  occupancy

Behaviour:
- Reset, synchronous and active-high: rd/wr pointers 0, count 0, valid and mshr_allow vectors 0, every credit counter = CREDIT_INIT. Consequently iss_valid_o=0, req_allowIn_o=1, queue_count_o=0. Payload arrays are not reset. Reset asserted mid-operation discards all entries and restores all credits.
- req_allowIn_o = (count != DEPTH). It ignores a same-cycle issue; no full-queue bypass.
- enq = req_valid_i & req_allowIn_o:
  - write payload at wr_ptr, set valid, set mshr_allow = ~req_need_linefill_i;
  - wr_ptr increments modulo DEPTH, wrapping naturally.
- Wakeup: when lf_done_valid_i, every valid entry with set_way_offset[SWO_W-1:1] == lf_done_set_way_i gets mshr_allow=1. This includes the entry being enqueued in the same cycle (bypass, no lost wakeup). mshr_allow never falls while an entry is valid.
- Issue is in order from rd_ptr:
  - iss_valid_o = valid[rd_ptr] & mshr_allow[rd_ptr] & (credit[ch[rd_ptr]] != 0), using registered state only.
  - fire = iss_valid_o & iss_ready_i. On fire, clear valid[rd_ptr] and increment rd_ptr modulo DEPTH.
  - A blocked head blocks all younger entries; no bypass.
- Minimum latency enqueue to iss_valid_o is 1 cycle (empty queue, no linefill needed, credit available). Wakeup to iss_valid_o is 1 cycle.
- Credits, per channel c: next = credit - (fire & ch==c) + credit_ret_i[c]. A simultaneous fire and return leaves the count unchanged. A return while at 2**CREDIT_W-1 saturates, and an assertion fires. A return arriving while credit==0 enables issue the next cycle.
- Count: next = count + enq - fire. Simultaneous enq and fire at count==DEPTH cannot happen because allowIn is 0.
- Stability: once iss_valid_o=1 it stays high with constant payload until fire, since credit only falls on fire and mshr_allow only rises.
- iss_* payload outputs are don't-care when iss_valid_o=0.

Decomposition:
- Package bank_isu_pkg holds the width parameters (ROB_W, SWO_W, WBUF_W, CH_W, CREDIT_W), CREDIT_INIT, and a packed entry-payload struct typedef.
- Sub-module bank_isu_credit_ctr: one per channel (generate loop). Inputs are consume and return; outputs are nonzero and count. It is reset to CREDIT_INIT and saturates at max.

Test Plan:
- Reset, then enqueue 1 entry (need_linefill=0, ch=2, rob=5), iss_ready=1 -> iss_valid_o=1 in the next cycle with rob=5; count returns 1->0 after fire.
- Enqueue 8 entries, iss_ready=0 -> req_allowIn_o=0 and count=8; the 9th request is dropped. Release iss_ready -> 8 issues in FIFO order, and pointers wrap correctly on the following enqueue.
- Head has need_linefill=1 with set_way 0x15, younger entry is ready -> nothing issues. lf_done (0x15) -> head issues the next cycle, then the younger entry.
- lf_done matching set_way in the same cycle as that entry's enqueue -> entry has mshr_allow=1 and issues with 1-cycle latency.
- Channel 1 with CREDIT_INIT=4, five ch=1 entries, iss_ready=1 -> 4 issue and the 5th stalls. Pulse credit_ret_i[1] -> the 5th issues one cycle later. Fire and return in the same cycle leave credit unchanged.
- Assert rst_i with 3 entries queued and credits partially consumed -> the next cycle shows count=0, iss_valid_o=0, credits=4 on all channels.
